// File: rtl/flat_mem_arbiter_if.sv
// Requester req/ack ports and DDR2 flat-port signals shared by flat_mem_arbiter.
// slave = arbiter view, master = requesters + controller view.
interface flat_mem_arbiter_if #(parameter int ADDR_W = 23);
    logic              m0_req, m0_we, m0_ack;
    logic [ADDR_W-1:0] m0_addr;
    logic [7:0]        m0_wdata, m0_rdata;
    logic              m1_req, m1_we, m1_ack;
    logic [ADDR_W-1:0] m1_addr;
    logic [7:0]        m1_wdata, m1_rdata;
    logic              mem_CEb, mem_WEb, mem_Q_oe, mem_ready;
    logic [ADDR_W-1:0] mem_A;
    logic [7:0]        mem_Q_out, mem_Q_in;
    logic              err;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata,
        input  mem_Q_in, mem_ready,
        output m0_ack, m0_rdata, m1_ack, m1_rdata,
        output mem_CEb, mem_WEb, mem_A, mem_Q_out, mem_Q_oe, err
    );
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata,
        output mem_Q_in, mem_ready,
        input  m0_ack, m0_rdata, m1_ack, m1_rdata,
        input  mem_CEb, mem_WEb, mem_A, mem_Q_out, mem_Q_oe, err
    );
endinterface

// File: rtl/flat_mem_arbiter.sv
// Two-port round-robin arbiter in front of the DDR2 controller flat CEb/WEb/A/Q port.
// Optional watchdog: define ARB_TIMEOUT_EN (otherwise err is tied low).
module flat_mem_arbiter #(
    parameter int ADDR_W     = 23,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 1023
) (
    input logic               clk,
    input logic               reset,
    flat_mem_arbiter_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_BUSY, S_DONE, S_GAP} state_t;
    localparam int GW = $clog2(GAP_CYCLES + 1);

    state_t        state;
    logic [GW-1:0] gap_cnt;
    logic          last_grant, grant;
    logic          any_req, pick, sel_we;
    logic [7:0]    rd_val;

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_cnt;
    logic          timed_out, to_hit;
    assign to_hit = (to_cnt == TW'(TIMEOUT - 1));
    assign rd_val = timed_out ? 8'hFF : bus.mem_Q_in;
`else
    assign rd_val  = bus.mem_Q_in;
    assign bus.err = 1'b0;
`endif

    // Both requesting: the port that did not win last time; otherwise the lone requester.
    always_comb begin
        any_req = bus.m0_req | bus.m1_req;
        pick    = (bus.m0_req & bus.m1_req) ? ~last_grant : bus.m1_req;
        sel_we  = pick ? bus.m1_we : bus.m0_we;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_GAP;
            gap_cnt      <= GW'(GAP_CYCLES);
            last_grant   <= 1'b1;
            grant        <= 1'b0;
            bus.mem_CEb  <= 1'b1;
            bus.mem_WEb  <= 1'b1;
            bus.mem_A    <= '0;
            bus.mem_Q_out <= 8'h00;
            bus.mem_Q_oe <= 1'b0;
            bus.m0_ack   <= 1'b0;
            bus.m1_ack   <= 1'b0;
            bus.m0_rdata <= 8'h00;
            bus.m1_rdata <= 8'h00;
`ifdef ARB_TIMEOUT_EN
            to_cnt       <= '0;
            timed_out    <= 1'b0;
            bus.err      <= 1'b0;
`endif
        end else begin
            bus.m0_ack <= 1'b0;
            bus.m1_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.mem_ready && any_req) begin
                        grant         <= pick;
                        bus.mem_A     <= pick ? bus.m1_addr : bus.m0_addr;
                        bus.mem_Q_out <= pick ? bus.m1_wdata : bus.m0_wdata;
                        bus.mem_WEb   <= ~sel_we;
                        bus.mem_Q_oe  <= sel_we;
                        bus.mem_CEb   <= 1'b0;
                        state         <= S_ISSUE;
`ifdef ARB_TIMEOUT_EN
                        to_cnt        <= '0;
                        timed_out     <= 1'b0;
`endif
                    end
                end
                // Controller acknowledges the CE falling edge by dropping ready.
                S_ISSUE: begin
                    if (!bus.mem_ready) state <= S_BUSY;
`ifdef ARB_TIMEOUT_EN
                    else if (to_hit) begin
                        timed_out <= 1'b1;
                        state     <= S_DONE;
                    end else to_cnt <= to_cnt + 1'b1;
`endif
                end
                S_BUSY: begin
                    if (bus.mem_ready) state <= S_DONE;
`ifdef ARB_TIMEOUT_EN
                    else if (to_hit) begin
                        timed_out <= 1'b1;
                        state     <= S_DONE;
                    end else to_cnt <= to_cnt + 1'b1;
`endif
                end
                S_DONE: begin
                    if (bus.mem_WEb) begin
                        if (grant) bus.m1_rdata <= rd_val;
                        else       bus.m0_rdata <= rd_val;
                    end
                    if (grant) bus.m1_ack <= 1'b1;
                    else       bus.m0_ack <= 1'b1;
                    bus.mem_CEb  <= 1'b1;
                    bus.mem_WEb  <= 1'b1;
                    bus.mem_Q_oe <= 1'b0;
                    last_grant   <= grant;
                    gap_cnt      <= GW'(GAP_CYCLES);
                    state        <= S_GAP;
`ifdef ARB_TIMEOUT_EN
                    if (timed_out) bus.err <= 1'b1;
`endif
                end
                // CEb stays high long enough for the controller to see a fresh falling edge.
                S_GAP: begin
                    if (gap_cnt <= GW'(1)) state <= S_IDLE;
                    else gap_cnt <= gap_cnt - 1'b1;
                end
                default: state <= S_GAP;
            endcase
        end
    end
endmodule
